// File: rtl/uart_rx_if.sv
// Byte-stream side of the UART receiver: AXI-Stream data handshake plus error pulses.
interface uart_rx_if;
  logic [7:0] M_axis_tdata;
  logic       M_axis_tvalid;
  logic       M_axis_tready;
  logic       Frame_err;
  logic       Overrun;
  logic       Parity_err;

  modport master (
    output M_axis_tdata, M_axis_tvalid, Frame_err, Overrun, Parity_err,
    input  M_axis_tready
  );

  modport slave (
    input  M_axis_tdata, M_axis_tvalid, Frame_err, Overrun, Parity_err,
    output M_axis_tready
  );
endinterface

// File: rtl/uart_rx.sv
// UART 8N1 receiver, LSB first, mid-bit sampling, AXI-Stream byte output.
// Define UART_RX_PARITY_EN for an 11-bit frame with an even parity bit before the stop bit.
module uart_rx #(
  parameter int CYCLES_PER_BIT = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic     Clk,
  input  logic     Rst,
  input  logic     Rx,
  uart_rx_if.master axis
);

  localparam int CW = $clog2(CYCLES_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CYCLES_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CYCLES_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [CW-1:0]          cyc_q;
  logic [2:0]             bit_q;
  logic [7:0]             shift_q;
  logic                   cyc_last, samp_data, byte_ok, ferr_d;
  logic [7:0]             tdata_q;
  logic                   tvalid_q, ferr_q, ovr_q;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, perr_d, perr_q;
`endif

  // Rx is asynchronous; synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], Rx};
  end
  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cyc_last  = 1'b0;
    samp_data = 1'b0;
    byte_ok   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE:  if (!rx_s) state_d = ST_START;
      // Half a bit in: confirm the start bit so short glitches are ignored.
      ST_START: if (cyc_q == HALF_M1) begin
        cyc_last = 1'b1;
        state_d  = rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA:  if (cyc_q == FULL_M1) begin
        cyc_last  = 1'b1;
        samp_data = 1'b1;
`ifdef UART_RX_PARITY_EN
        if (bit_q == 3'd7) state_d = ST_PARITY;
`else
        if (bit_q == 3'd7) state_d = ST_STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (cyc_q == FULL_M1) begin
        cyc_last = 1'b1;
        state_d  = ST_STOP;
      end
`endif
      ST_STOP:  if (cyc_q == FULL_M1) begin
        cyc_last = 1'b1;
        if (rx_s) begin
          state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
          if (par_q != ^shift_q) perr_d  = 1'b1;
          else                   byte_ok = 1'b1;
`else
          byte_ok = 1'b1;
`endif
        end else begin
          ferr_d  = 1'b1;
          state_d = ST_BREAK;
        end
      end
      // Held-low line: wait for idle before hunting for the next start bit.
      ST_BREAK: if (rx_s) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (state_q == ST_IDLE || state_q == ST_BREAK) begin
      cyc_q <= '0;
      bit_q <= '0;
    end else begin
      cyc_q <= cyc_last ? '0 : cyc_q + CW'(1);
      if (samp_data) begin
        shift_q[bit_q] <= rx_s;
        bit_q          <= bit_q + 3'd1;
      end
`ifdef UART_RX_PARITY_EN
      if (state_q == ST_PARITY && cyc_last) par_q <= rx_s;
`endif
    end
  end

  // Receiver never waits on tready: a byte arriving into an occupied slot is dropped.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      tdata_q  <= 8'h00;
      tvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      ferr_q <= ferr_d;
      ovr_q  <= 1'b0;
      if (byte_ok) begin
        if (!tvalid_q || axis.M_axis_tready) begin
          tdata_q  <= shift_q;
          tvalid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (tvalid_q && axis.M_axis_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) perr_q <= 1'b0;
    else     perr_q <= perr_d;
  end
  assign axis.Parity_err = perr_q;
`else
  assign axis.Parity_err = 1'b0;
`endif

  assign axis.M_axis_tdata  = tdata_q;
  assign axis.M_axis_tvalid = tvalid_q;
  assign axis.Frame_err     = ferr_q;
  assign axis.Overrun       = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame vectors, corner sequences, random frames, 8x oversampling.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam real TCLK   = 10.0;
  localparam real BIT16  = 16 * TCLK;
  localparam real BIT8   = 8 * TCLK;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic rx16 = 1'b1;
  logic rx8  = 1'b1;
  always #5 Clk = ~Clk;

  uart_rx_if if16();
  uart_rx_if if8();

  uart_rx #(.CYCLES_PER_BIT(16), .SYNC_STAGES(2)) dut16 (
    .Clk(Clk), .Rst(Rst), .Rx(rx16), .axis(if16.master));
  uart_rx #(.CYCLES_PER_BIT(8), .SYNC_STAGES(2)) dut8 (
    .Clk(Clk), .Rst(Rst), .Rx(rx8), .axis(if8.master));

  int checks = 0;
  int errors = 0;
  logic [7:0] got16[$];
  logic [7:0] got8[$];
  int ferr16 = 0, ovr16 = 0, perr16 = 0, ferr8 = 0;

  // Observer: records accepted bytes and error pulses as cumulative logs.
  always @(negedge Clk) begin
    if (!Rst) begin
      if (if16.M_axis_tvalid && if16.M_axis_tready) got16.push_back(if16.M_axis_tdata);
      if (if16.Frame_err)  ferr16++;
      if (if16.Overrun)    ovr16++;
      if (if16.Parity_err) perr16++;
      if (if8.M_axis_tvalid && if8.M_axis_tready) got8.push_back(if8.M_axis_tdata);
      if (if8.Frame_err)   ferr8++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Serialises one frame as a transmitter would; leaves the line at the stop-bit level.
  task automatic send(input bit sel8, input logic [7:0] d, input bit stop,
                      input bit pflip, input real bit_ns);
    bit seq[$];
    seq.push_back(1'b0);
    for (int i = 0; i < 8; i++) seq.push_back(d[i]);
    if (PAR_EN) seq.push_back((^d) ^ pflip);
    seq.push_back(stop);
    foreach (seq[i]) begin
      if (sel8) rx8 = seq[i];
      else      rx16 = seq[i];
      #(bit_ns);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    bit         stop;
    bit         pflip;
    int         exp_bytes;
    int         exp_ferr;
    int         exp_perr;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] d, input bit stop, input bit pflip);
    vec_t v;
    v.d         = d;
    v.stop      = stop;
    v.pflip     = pflip;
    v.exp_bytes = (stop && !(pflip && PAR_EN)) ? 1 : 0;
    v.exp_ferr  = stop ? 0 : 1;
    v.exp_perr  = (stop && pflip && PAR_EN) ? 1 : 0;
    return v;
  endfunction

  initial begin
    vec_t vecs[6];
    int b, f, p, o;
    logic [7:0] exp_q[$];
    int exp_ferr, exp_perr;

    vecs[0] = mk(8'hA5, 1'b1, 1'b0);
    vecs[1] = mk(8'h00, 1'b1, 1'b0);
    vecs[2] = mk(8'hFF, 1'b1, 1'b0);
    vecs[3] = mk(8'h3C, 1'b0, 1'b0);
    vecs[4] = mk(8'h81, 1'b1, 1'b1);
    vecs[5] = mk(8'h6E, 1'b1, 1'b0);

    if16.M_axis_tready = 1'b1;
    if8.M_axis_tready  = 1'b1;

    #23;
    chk("rst_tdata",  if16.M_axis_tdata,  0);
    chk("rst_tvalid", if16.M_axis_tvalid, 0);
    chk("rst_ferr",   if16.Frame_err,     0);
    chk("rst_ovr",    if16.Overrun,       0);
    chk("rst_perr",   if16.Parity_err,    0);
    @(negedge Clk);
    Rst = 1'b0;
    #(5 * TCLK);

    foreach (vecs[i]) begin
      b = got16.size(); f = ferr16; p = perr16;
      send(1'b0, vecs[i].d, vecs[i].stop, vecs[i].pflip, BIT16);
      rx16 = 1'b1;
      #(3 * BIT16);
      chk("vec_bytes", got16.size() - b, vecs[i].exp_bytes);
      if (vecs[i].exp_bytes == 1 && got16.size() > b) chk("vec_data", got16[b], vecs[i].d);
      chk("vec_ferr", ferr16 - f, vecs[i].exp_ferr);
      chk("vec_perr", perr16 - p, vecs[i].exp_perr);
    end

    // Short low glitch on an idle line must not start a frame.
    b = got16.size(); f = ferr16;
    rx16 = 1'b0; #(4 * TCLK); rx16 = 1'b1;
    #(2 * BIT16);
    chk("glitch_bytes", got16.size() - b, 0);
    send(1'b0, 8'h5A, 1'b1, 1'b0, BIT16);
    #(3 * BIT16);
    chk("glitch_next_bytes", got16.size() - b, 1);
    if (got16.size() > b) chk("glitch_next_data", got16[b], 8'h5A);
    chk("glitch_ferr", ferr16 - f, 0);

    // Bad stop bit then line held low: one framing error, no bytes.
    b = got16.size(); f = ferr16;
    send(1'b0, 8'h3C, 1'b0, 1'b0, BIT16);
    #(40 * BIT16);
    chk("break_ferr", ferr16 - f, 1);
    chk("break_bytes", got16.size() - b, 0);
    rx16 = 1'b1;
    #(2 * BIT16);
    send(1'b0, 8'h55, 1'b1, 1'b0, BIT16);
    #(3 * BIT16);
    chk("break_next_bytes", got16.size() - b, 1);
    if (got16.size() > b) chk("break_next_data", got16[b], 8'h55);

    // Overrun: second byte arrives while the first is still unaccepted.
    if16.M_axis_tready = 1'b0;
    b = got16.size(); o = ovr16;
    send(1'b0, 8'h11, 1'b1, 1'b0, BIT16);
    #(BIT16);
    send(1'b0, 8'h22, 1'b1, 1'b0, BIT16);
    #(2 * BIT16);
    chk("ovr_tvalid", if16.M_axis_tvalid, 1);
    chk("ovr_tdata", if16.M_axis_tdata, 8'h11);
    chk("ovr_pulses", ovr16 - o, 1);
    @(posedge Clk); #1;
    if16.M_axis_tready = 1'b1;
    #(3 * TCLK);
    chk("ovr_drain_tvalid", if16.M_axis_tvalid, 0);
    chk("ovr_drain_bytes", got16.size() - b, 1);
    if (got16.size() > b) chk("ovr_drain_data", got16[b], 8'h11);

    // Asynchronous reset in the middle of a frame, with a byte pending.
    if16.M_axis_tready = 1'b0;
    send(1'b0, 8'h33, 1'b1, 1'b0, BIT16);
    #(BIT16);
    chk("pre_rst_tvalid", if16.M_axis_tvalid, 1);
    fork
      send(1'b0, 8'hFF, 1'b1, 1'b0, BIT16);
      begin
        #(5.5 * BIT16 + 3.0);
        Rst = 1'b1;
        #1;
        chk("midrst_tvalid", if16.M_axis_tvalid, 0);
        chk("midrst_tdata", if16.M_axis_tdata, 0);
      end
    join
    if16.M_axis_tready = 1'b1;
    #(2 * BIT16);
    @(negedge Clk);
    Rst = 1'b0;
    #(BIT16);
    b = got16.size();
    send(1'b0, 8'h0F, 1'b1, 1'b0, BIT16);
    #(3 * BIT16);
    chk("post_rst_bytes", got16.size() - b, 1);
    if (got16.size() > b) chk("post_rst_data", got16[b], 8'h0F);

`ifdef UART_RX_PARITY_EN
    b = got16.size(); p = perr16;
    send(1'b0, 8'h07, 1'b1, 1'b0, BIT16);
    #(3 * BIT16);
    chk("par_ok_bytes", got16.size() - b, 1);
    if (got16.size() > b) chk("par_ok_data", got16[b], 8'h07);
    send(1'b0, 8'h07, 1'b1, 1'b1, BIT16);
    #(3 * BIT16);
    chk("par_bad_bytes", got16.size() - b, 1);
    chk("par_bad_perr", perr16 - p, 1);
`endif

    // 8x oversampling with a transmitter 3% slow and 3% fast.
    b = got8.size(); f = ferr8;
    send(1'b1, 8'hC3, 1'b1, 1'b0, BIT8 * 1.03);
    #(3 * BIT8);
    send(1'b1, 8'hC3, 1'b1, 1'b0, BIT8 * 0.97);
    #(3 * BIT8);
    chk("cpb8_bytes", got8.size() - b, 2);
    if (got8.size() > b)     chk("cpb8_slow_data", got8[b], 8'hC3);
    if (got8.size() > b + 1) chk("cpb8_fast_data", got8[b + 1], 8'hC3);
    chk("cpb8_ferr", ferr8 - f, 0);

    // Random frames against a frame-level reference model.
    b = got16.size(); f = ferr16; p = perr16;
    exp_ferr = 0; exp_perr = 0;
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      bit stop, pflip;
      d     = 8'($urandom);
      stop  = ($urandom_range(0, 5) != 0);
      pflip = ($urandom_range(0, 3) == 0);
      send(1'b0, d, stop, pflip, BIT16);
      rx16 = 1'b1;
      #($urandom_range(1, 3) * BIT16);
      if (!stop)             exp_ferr++;
      else if (pflip && PAR_EN) exp_perr++;
      else                   exp_q.push_back(d);
    end
    #(2 * BIT16);
    chk("rand_bytes", got16.size() - b, exp_q.size());
    foreach (exp_q[i])
      if (got16.size() > b + i) chk("rand_data", got16[b + i], exp_q[i]);
    chk("rand_ferr", ferr16 - f, exp_ferr);
    chk("rand_perr", perr16 - p, exp_perr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
